eat_detector: RTL
=================

# eat_detector

Consumer-side partner of the food generator: samples the snake head position on each game-move tick and compares it against the current food position. On a hit it issues the one-cycle `food_eaten` request that makes the food generator respawn. It then waits for the respawned position before re-arming. It also keeps the score and schedules snake growth. Sits between the snake movement logic (head position, move tick) and the food generator / score display.

## Interface
- `GROW_PER_FOOD`, default 3 — segments added per food eaten.
- `SCORE_W`, default 16 — score counter width.
- `PEND_W`, default 6 — grow-pending counter width.
- `RESPAWN_TIMEOUT`, default 15 — cycles to wait for a new food position before forced re-arm.
- `clk`  in  1 — system clock; all state changes on the rising edge.
- `reset`  in  1 — asynchronous, active-low reset.
- `restart`  in  1 — synchronous game restart; clears state, same effect as reset.
- `tick`  in  1 — one-cycle move strobe; `head_x`/`head_y` are valid in the tick cycle.
- `head_x`  in  10 — head pixel x, a multiple of SEGMENT_SIZE.
- `head_y`  in  10 — head pixel y, a multiple of SEGMENT_SIZE.
- `food_x`  in  10 — current food x from the food generator.
- `food_y`  in  10 — current food y from the food generator.
- `food_eaten`  out  1 — registered one-cycle respawn request.
- `grow_step`  out  1 — registered one-cycle pulse: the snake keeps its tail on this move.
- `score`  out  SCORE_W — foods eaten; saturates.
- `respawn_err`  out  1 — sticky flag: a respawn timeout has occurred.

## Operation
- **FSM states:** ARMED and WAIT_NEW. Reset and `restart` enter ARMED.
- **ARMED, hit:** on a `tick` cycle with `head_x==food_x && head_y==food_y`:
  - assert `food_eaten` next cycle;
  - latch `food_x`/`food_y` into `last_x`/`last_y`;
  - `score += 1`, saturating at 2^SCORE_W−1;
  - `pend += GROW_PER_FOOD`, saturating at 2^PEND_W−1;
  - go to WAIT_NEW and clear the timeout counter.
- **ARMED, no eat:** no eat evaluation without `tick`. A mismatch on tick has no effect.
- **WAIT_NEW:** eat evaluation is disabled and ticks do not eat. Each cycle:
  - if `(food_x,food_y) != (last_x,last_y)`, go to ARMED;
  - else if the timeout counter equals RESPAWN_TIMEOUT, set `respawn_err` and go to ARMED;
  - else increment the counter.
- **Re-arm without tick:** entering ARMED never evaluates a hit without a fresh `tick`. New food placed under the head is eaten only if the head is still there on the next tick.
- **Growth:** on any `tick` with `pend>0` (either state), `grow_step` is asserted next cycle and `pend` decrements.
- **Eat and growth on the same tick:** `pend_next = sat(pend − 1 + GROW_PER_FOOD)`, and `grow_step` is asserted.
- **Priority:** `reset` (async) > `restart` > normal operation. `restart` during WAIT_NEW discards the pending respawn wait.

## Timing
- **Reset values:** `food_eaten=0`, `grow_step=0`, `score=0`, `respawn_err=0`; `pend=0`; state ARMED; `last_x/last_y=0`; timeout counter 0.
- **Eat latency:** tick plus hit in cycle n gives `food_eaten=1` in cycle n+1 only and the score update visible in n+1.
- **Earliest re-arm:** the food generator updates position in cycle n+2, so the earliest re-arm is the edge ending n+2, i.e. ARMED in n+3. The first possible next eat is a tick in n+3, with `food_eaten` in n+4.
- **Growth latency:** tick in cycle n gives `grow_step` in n+1.
- **Pulse widths:** all outputs are registered, and `food_eaten` is never high on two consecutive cycles.
- **Back-to-back ticks:** a tick on every cycle is legal. Growth is still one step per tick.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. Deassertion is synchronized by the surrounding reset logic.

## Structure
- A shared package/include `snek_defs` holds:
  - SCREEN_W=640, SCREEN_H=480, SEGMENT_SIZE=10, the position width (10);
  - the eat_detector state encoding (ARMED=1'b0, WAIT_NEW=1'b1).
- No sub-modules are required.
- The saturating add/decrement is a local function, reused for `score` and `pend`.

## Test plan
- **Reset/restart:** assert `reset` low mid-run with score=5, pend=2 → all outputs 0 immediately. Same check with `restart` for 1 cycle → all zero on the next cycle.
- **Single eat:**
  - Setup: head=(100,50), food=(100,50), tick at cycle n.
  - Required: `food_eaten` high only in n+1; score=1, pend=3.
  - Follow-up: food moves to (300,200) at n+2 → state ARMED at n+3.
  - Follow-up: a tick at n+3 with the head at (300,200) → a second `food_eaten` at n+4.
- **No double eat:** hold head=food=(100,50), food never changes, ticks every cycle:
  - exactly one `food_eaten`;
  - `respawn_err` set after 16 WAIT_NEW cycles;
  - next tick at the same head → second eat, score=2.
- **Growth:** one eat, then 5 ticks → `grow_step` on the first 3 ticks only, pend=0. An eat on the tick when pend=1 → `grow_step` asserted, pend=3.
- **Saturation:** SCORE_W=4 with 17 eats → score stays 15. PEND_W=2 with 2 eats and no ticks → pend=3.
- **Miss/no tick:** head=food without tick for 10 cycles → no `food_eaten`. Tick with head=(110,50), food=(100,50) → no eat, score unchanged.

Source files
------------

// File: rtl/snek_defs.sv
// Shared snake-game definitions: screen geometry, position width and the
// eat_detector state encoding.
package snek_defs;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SEGMENT_SIZE = 10;
  localparam int POS_W        = 10;

  typedef enum logic {
    ARMED    = 1'b0,
    WAIT_NEW = 1'b1
  } eat_state_e;

endpackage

// File: rtl/eat_detector.sv
// Detects the snake head landing on the food, requests a respawn, waits for
// the new food position, and keeps the score and the pending-growth count.
//
// state    | meaning
// ARMED    | a tick with head == food is an eat
// WAIT_NEW | eat issued; waiting for the food generator to move the food
module eat_detector
  import snek_defs::*;
#(
  parameter int GROW_PER_FOOD   = 3,
  parameter int SCORE_W         = 16,
  parameter int PEND_W          = 6,
  parameter int RESPAWN_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               tick,
  input  logic [POS_W-1:0]   head_x,
  input  logic [POS_W-1:0]   head_y,
  input  logic [POS_W-1:0]   food_x,
  input  logic [POS_W-1:0]   food_y,
  output logic               food_eaten,
  output logic               grow_step,
  output logic [SCORE_W-1:0] score,
  output logic               respawn_err
);

  localparam int TMO_W = (RESPAWN_TIMEOUT < 1) ? 1 : $clog2(RESPAWN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESPAWN_TIMEOUT);
  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
  localparam logic [31:0] PEND_MAX  = 32'((64'd1 << PEND_W) - 64'd1);
  localparam logic [31:0] GROW_INC  = 32'(GROW_PER_FOOD);

  // val + inc (minus one when dec), clamped to max_val. A decrement is only
  // requested when val > 0, so the sum never underflows.
  function automatic logic [31:0] sat_step(input logic [31:0] val,
                                           input logic [31:0] inc,
                                           input logic        dec,
                                           input logic [31:0] max_val);
    logic [32:0] sum;
    logic [31:0] res;
    sum = {1'b0, val} + {1'b0, inc};
    if (dec) sum = sum - 33'd1;
    if (sum > {1'b0, max_val}) res = max_val;
    else                       res = sum[31:0];
    return res;
  endfunction

  eat_state_e         state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [POS_W-1:0]   last_x_q, last_x_d, last_y_q, last_y_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               food_eaten_q, food_eaten_d;
  logic               grow_step_q, grow_step_d;
  logic               err_q, err_d;
  logic               eat, err_set, grow, food_moved;

  assign food_moved = (food_x != last_x_q) || (food_y != last_y_q);
  assign grow       = tick && (pend_q != '0);

  // State register; restart has priority over normal operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       state_q <= ARMED;
    else if (restart) state_q <= ARMED;
    else              state_q <= state_d;
  end

  // Next state, eat detection and respawn-timeout bookkeeping.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    eat     = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (tick && head_x == food_x && head_y == food_y) begin
          eat     = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_NEW;
        end
      end
      WAIT_NEW: begin
        if (food_moved) begin
          state_d = ARMED;
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          state_d = ARMED;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // Next values of the registered outputs, score, growth and last food position.
  always_comb begin
    food_eaten_d = eat;
    grow_step_d  = grow;
    err_d        = err_q | err_set;
    last_x_d     = eat ? food_x : last_x_q;
    last_y_d     = eat ? food_y : last_y_q;
    score_d      = score_q;
    pend_d       = pend_q;
    if (eat)
      score_d = SCORE_W'(sat_step(32'(score_q), 32'd1, 1'b0, SCORE_MAX));
    if (eat || grow)
      pend_d = PEND_W'(sat_step(32'(pend_q), eat ? GROW_INC : 32'd0, grow, PEND_MAX));
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q        <= '0;
      last_x_q     <= '0;
      last_y_q     <= '0;
      score_q      <= '0;
      pend_q       <= '0;
      food_eaten_q <= 1'b0;
      grow_step_q  <= 1'b0;
      err_q        <= 1'b0;
    end else if (restart) begin
      tmo_q        <= '0;
      last_x_q     <= '0;
      last_y_q     <= '0;
      score_q      <= '0;
      pend_q       <= '0;
      food_eaten_q <= 1'b0;
      grow_step_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      score_q      <= score_d;
      pend_q       <= pend_d;
      food_eaten_q <= food_eaten_d;
      grow_step_q  <= grow_step_d;
      err_q        <= err_d;
    end
  end

  assign food_eaten  = food_eaten_q;
  assign grow_step   = grow_step_q;
  assign score       = score_q;
  assign respawn_err = err_q;

endmodule
